// File: rtl/cfg_cmd_pkg.sv
// Shared definitions for the config command dispatcher: command codes,
// FSM state encoding and default response words.
package cfg_cmd_pkg;

    localparam logic [1:0] CMD_WR   = 2'b00;
    localparam logic [1:0] CMD_RD   = 2'b01;
    localparam logic [1:0] CMD_PING = 2'b10;
    localparam logic [1:0] CMD_BAD  = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DECODE = 3'd1,
        BUS_WR = 3'd2,
        BUS_RD = 3'd3,
        RESP   = 3'd4,
        CLR    = 3'd5
    } state_t;

    localparam logic [15:0] ACK_CODE_DEF = 16'hA5A5;
    localparam logic [15:0] ERR_CODE_DEF = 16'hEEEE;
    localparam logic [15:0] TMO_CODE_DEF = 16'hDEAD;

endpackage

// File: rtl/cfg_cmd_dispatch.sv
// Takes one received config frame, performs a single register-bus write/read
// (or echo), and hands a 16-bit response back to the UART.
//
// state  | meaning
// IDLE   | waiting for frm_rdy; captures the frame
// DECODE | splits the frame into a bus access or an immediate response
// BUS_WR | reg_we held until reg_ack or timeout
// BUS_RD | reg_re held until reg_ack or timeout
// RESP   | one-cycle snd_rsp pulse
// CLR    | clr_frm_rdy held until the UART drops frm_rdy
module cfg_cmd_dispatch
    import cfg_cmd_pkg::*;
#(
    parameter int                ADDR_W   = 6,
    parameter int                DATA_W   = 16,
    parameter int                TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ACK_CODE = ACK_CODE_DEF,
    parameter logic [DATA_W-1:0] ERR_CODE = ERR_CODE_DEF,
    parameter logic [DATA_W-1:0] TMO_CODE = TMO_CODE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frm_rdy,
    input  logic [23:0]       cfg_data,
    output logic              snd_rsp,
    output logic              clr_frm_rdy,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_we,
    output logic              reg_re,
    input  logic              reg_ack,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    // Bus timer runs down from TIMEOUT; a value of 1 marks the last allowed bus cycle.
    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT);

    state_t            state, state_nxt;
    logic [23:0]       cmd_q, cmd_nxt;
    logic [7:0]        tmr, tmr_nxt;
    logic [DATA_W-1:0] rsp_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic              err_inc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cmd_q     <= '0;
            tmr       <= '0;
            rsp_data  <= '0;
            reg_addr  <= '0;
            reg_wdata <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            cmd_q     <= cmd_nxt;
            tmr       <= tmr_nxt;
            rsp_data  <= rsp_nxt;
            reg_addr  <= addr_nxt;
            reg_wdata <= wdata_nxt;
            if (err_inc && (err_cnt != 8'hFF))
                err_cnt <= err_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_nxt   = cmd_q;
        tmr_nxt   = tmr;
        rsp_nxt   = rsp_data;
        addr_nxt  = reg_addr;
        wdata_nxt = reg_wdata;
        err_inc   = 1'b0;
        case (state)
            IDLE: begin
                if (frm_rdy) begin
                    cmd_nxt   = cfg_data;
                    state_nxt = DECODE;
                end
            end
            DECODE: begin
                tmr_nxt = TMR_LOAD;
                case (cmd_q[23:22])
                    CMD_WR: begin
                        addr_nxt  = ADDR_W'(cmd_q[21:16]);
                        wdata_nxt = DATA_W'(cmd_q[15:0]);
                        state_nxt = BUS_WR;
                    end
                    CMD_RD: begin
                        addr_nxt  = ADDR_W'(cmd_q[21:16]);
                        state_nxt = BUS_RD;
                    end
                    CMD_PING: begin
                        rsp_nxt   = DATA_W'(cmd_q[15:0]);
                        state_nxt = RESP;
                    end
                    default: begin
                        rsp_nxt   = ERR_CODE;
                        err_inc   = 1'b1;
                        state_nxt = RESP;
                    end
                endcase
            end
            BUS_WR, BUS_RD: begin
                // Ack is checked before the timer so a last-cycle ack still succeeds.
                if (reg_ack) begin
                    rsp_nxt   = (state == BUS_WR) ? ACK_CODE : reg_rdata;
                    state_nxt = RESP;
                end else if (tmr == 8'd1) begin
                    rsp_nxt   = TMO_CODE;
                    err_inc   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    tmr_nxt = tmr - 8'd1;
                end
            end
            RESP: state_nxt = CLR;
            CLR: begin
                if (!frm_rdy)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign snd_rsp     = (state == RESP);
    assign clr_frm_rdy = (state == CLR) && frm_rdy;
    assign reg_we      = (state == BUS_WR);
    assign reg_re      = (state == BUS_RD);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_cfg_cmd_dispatch.sv
// Scoreboard bench for cfg_cmd_dispatch: expected responses are queued when a
// frame is driven and checked when snd_rsp fires; a small bus model supplies acks.
module tb_cfg_cmd_dispatch;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        frm_rdy;
    logic [23:0] cfg_data;
    logic        snd_rsp;
    logic        clr_frm_rdy;
    logic [15:0] rsp_data;
    logic [5:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_we;
    logic        reg_re;
    logic        reg_ack;
    logic [15:0] reg_rdata;
    logic        busy;
    logic [7:0]  err_cnt;

    cfg_cmd_dispatch #(.TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .frm_rdy     (frm_rdy),
        .cfg_data    (cfg_data),
        .snd_rsp     (snd_rsp),
        .clr_frm_rdy (clr_frm_rdy),
        .rsp_data    (rsp_data),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_we      (reg_we),
        .reg_re      (reg_re),
        .reg_ack     (reg_ack),
        .reg_rdata   (reg_rdata),
        .busy        (busy),
        .err_cnt     (err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] rsp;
        int          cyc;
        logic [7:0]  err;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] mdl_err;
    int         n_chk = 0;
    int         n_err = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // ack_at: strobe cycle (1-based) on which reg_ack is returned, 0 = never.
    // hold:   extra cycles frm_rdy stays high after clr_frm_rdy rises.
    // ack_idle: level driven on reg_ack outside bus states.
    task automatic run_frame(input logic [23:0] frame, input int ack_at,
                             input logic [15:0] rdata, input int hold, input logic ack_idle);
        exp_t e;
        exp_t got;
        int   strobes;
        int   cyc;
        int   seen_str;
        int   snd_n;
        int   clr_seen;
        bit   done;
        strobes = 0;
        case (frame[23:22])
            2'b10: e.rsp = frame[15:0];
            2'b11: begin
                e.rsp = 16'hEEEE;
                if (mdl_err != 8'hFF) mdl_err++;
            end
            default: begin
                if (ack_at >= 1 && ack_at <= TMO) begin
                    strobes = ack_at;
                    e.rsp   = (frame[23:22] == 2'b00) ? 16'hA5A5 : rdata;
                end else begin
                    strobes = TMO;
                    e.rsp   = 16'hDEAD;
                    if (mdl_err != 8'hFF) mdl_err++;
                end
            end
        endcase
        e.cyc = 2 + strobes;
        e.err = mdl_err;
        sb.push_back(e);

        @(posedge clk);
        #1;
        frm_rdy  = 1'b1;
        cfg_data = frame;
        cyc = 0; seen_str = 0; snd_n = 0; clr_seen = 0; done = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            if (reg_we || reg_re) begin
                seen_str++;
                chk("we_re_excl", {31'b0, reg_we & reg_re}, 32'd0);
                chk("reg_addr", {26'b0, reg_addr}, {26'b0, frame[21:16]});
                if (reg_we) chk("reg_wdata", {16'b0, reg_wdata}, {16'b0, frame[15:0]});
                reg_ack   = (seen_str == ack_at);
                reg_rdata = (seen_str == ack_at) ? rdata : 16'h0BAD;
            end else begin
                reg_ack   = ack_idle;
                reg_rdata = 16'h0BAD;
            end
            if (snd_rsp) begin
                snd_n++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'd1, 32'd0);
                end else begin
                    got = sb.pop_front();
                    chk("rsp_data", {16'b0, rsp_data}, {16'b0, got.rsp});
                    chk("rsp_cycle", cyc, got.cyc);
                    chk("err_cnt", {24'b0, err_cnt}, {24'b0, got.err});
                end
            end
            if (clr_frm_rdy) begin
                if (clr_seen == hold) frm_rdy = 1'b0;
                clr_seen++;
            end
            if (!frm_rdy && !busy) done = 1;
            cyc++;
        end
        reg_ack = 1'b0;
        chk("frame_done", {31'b0, done}, 32'd1);
        chk("snd_once", snd_n, 32'd1);
        chk("strobe_cycles", seen_str, strobes);
        chk("clr_hold", clr_seen, hold + 1);
        chk("rsp_held", {16'b0, rsp_data}, {16'b0, e.rsp});
        repeat (2) begin
            @(negedge clk);
            chk("idle_after", {30'b0, busy, snd_rsp}, 32'd0);
        end
    endtask

    task automatic reset_mid_read();
        int   seen;
        int   cyc;
        @(posedge clk);
        #1;
        frm_rdy  = 1'b1;
        cfg_data = 24'h4A_0000;
        seen = 0; cyc = 0;
        while (seen < 2 && cyc < 50) begin
            @(negedge clk);
            reg_ack = 1'b0;
            if (reg_re) seen++;
            cyc++;
        end
        chk("rst_reached_bus", seen, 32'd2);
        rst     = 1'b1;
        frm_rdy = 1'b0;
        @(negedge clk);
        chk("rst_reg_re", {31'b0, reg_re}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
        chk("rst_err_cnt", {24'b0, err_cnt}, 32'd0);
        chk("rst_reg_addr", {26'b0, reg_addr}, 32'd0);
        rst     = 1'b0;
        mdl_err = 8'd0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_no_snd", {30'b0, snd_rsp, busy}, 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        frm_rdy   = 1'b0;
        cfg_data  = '0;
        reg_ack   = 1'b0;
        reg_rdata = '0;
        mdl_err   = 8'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {busy, snd_rsp, clr_frm_rdy, reg_we, reg_re, err_cnt}, 32'd0);
        chk("reset_data", {rsp_data, reg_wdata}, 32'd0);
        chk("reset_addr", {26'b0, reg_addr}, 32'd0);
        rst = 1'b0;

        run_frame(24'h05_1234, 1, 16'h0000, 0, 1'b1);   // write, ack tied high
        run_frame(24'h4A_0000, 4, 16'hBEEF, 0, 1'b0);   // read, 3 wait cycles
        run_frame(24'h4A_0000, 0, 16'h0000, 0, 1'b0);   // read timeout
        run_frame(24'h41_0000, 4, 16'h1357, 0, 1'b0);   // ack on last cycle
        run_frame(24'h13_5555, 0, 16'h0000, 0, 1'b0);   // write timeout
        run_frame(24'h80_C0DE, 0, 16'h0000, 0, 1'b1);   // ping, stray ack ignored
        run_frame(24'hC0_0000, 0, 16'h0000, 0, 1'b0);   // invalid
        run_frame(24'h3F_FFFF, 2, 16'h0000, 3, 1'b0);   // handshake hold
        run_frame(24'h7F_0000, 1, 16'h8001, 1, 1'b0);
        for (int i = 0; i < 256; i++)
            run_frame({2'b11, 22'(i)}, 0, 16'h0000, 0, 1'b0);
        chk("err_saturated", {24'b0, err_cnt}, 32'h0000_00FF);

        reset_mid_read();
        run_frame(24'h80_4242, 0, 16'h0000, 0, 1'b0);
        run_frame(24'h4A_0000, 1, 16'hCAFE, 0, 1'b0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_cmd_dispatch.md
Name: cfg_cmd_dispatch

Overview:
- Sequences cfg_UART: waits for a received 24-bit config frame (frm_rdy), decodes it, runs one write or read on the on-chip config register bus, then returns a 16-bit response over the UART.
- Sits between cfg_UART and the config register bus.
- Sole owner of snd_rsp, clr_frm_rdy and rsp_data.

Parameters:
- ADDR_W, 6, register bus address width (frame opcode[5:0]).
- DATA_W, 16, register data width and response width.
- TIMEOUT, 255, maximum bus cycles to wait for reg_ack (1..255).
- ACK_CODE, 16'hA5A5, response for a successful write.
- ERR_CODE, 16'hEEEE, response for an invalid command.
- TMO_CODE, 16'hDEAD, response for a bus timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frm_rdy  in  1  frame available from cfg_UART
- cfg_data  in  24  frame: [23:22] cmd, [21:16] addr, [15:0] data
- snd_rsp  out  1  one-cycle pulse: cfg_UART starts sending rsp_data
- clr_frm_rdy  out  1  clear request to cfg_UART
- rsp_data  out  16  response word, held stable until the next response
- reg_addr  out  ADDR_W  bus address
- reg_wdata  out  DATA_W  bus write data
- reg_we  out  1  write strobe, held until ack or timeout
- reg_re  out  1  read strobe, held until ack or timeout
- reg_ack  in  1  bus completion; sampled only while reg_we/reg_re is high
- reg_rdata  in  DATA_W  read data, valid with reg_ack
- busy  out  1  high in every state except IDLE
- err_cnt  out  8  saturating count of invalid commands plus timeouts

Behaviour:
- Reset: one clock, synchronous active-high, as decided above. On rst high at a clock edge:
  - State goes to IDLE.
  - All outputs go to 0: rsp_data, reg_addr, reg_wdata, err_cnt, all strobes, snd_rsp, clr_frm_rdy, busy.
  - Reset mid-transfer drops the bus strobes at that edge. No response is sent.
- Command codes in cfg_data[23:22]:
  - 00 = WRITE
  - 01 = READ
  - 10 = PING (echo)
  - 11 = invalid
- State machine:
  - IDLE: when frm_rdy=1, register cfg_data into an internal cmd register and go to DECODE.
  - DECODE:
    - WRITE: load reg_addr/reg_wdata, go to BUS_WR.
    - READ: load reg_addr, go to BUS_RD.
    - PING: rsp_data<=cmd[15:0], go to RESP.
    - Invalid: rsp_data<=ERR_CODE, err_cnt+1, go to RESP.
  - BUS_WR / BUS_RD:
    - Assert reg_we or reg_re. A 8-bit timer counts bus cycles starting at 1.
    - reg_ack=1: WRITE sets rsp_data<=ACK_CODE; READ sets rsp_data<=reg_rdata. Drop the strobe, go to RESP.
    - No ack by bus cycle TIMEOUT: rsp_data<=TMO_CODE, err_cnt+1, drop the strobe, go to RESP.
    - Ack on the TIMEOUT-th cycle: ack wins, no error is counted.
  - RESP: snd_rsp=1 for exactly one cycle; go to CLR.
  - CLR: hold clr_frm_rdy=1 while frm_rdy=1. On the first cycle frm_rdy is seen low, go to IDLE with clr_frm_rdy=0.
- Latency, with frm_rdy seen in IDLE at cycle 0:
  - PING/invalid: snd_rsp at cycle 2.
  - Write/read with zero-wait ack: strobe at cycle 2, snd_rsp at cycle 3.
  - Each extra bus wait cycle adds 1.
- Holding rules:
  - rsp_data changes only on the transition into RESP. It is registered and stable through the whole cfg_UART transmit.
  - reg_addr/reg_wdata hold their value after the access.
- Ignored inputs:
  - reg_ack outside BUS states is ignored.
  - frm_rdy is ignored in every state except IDLE; a frame is never lost, because frm_rdy stays high until cleared.
- err_cnt saturates at 8'hFF.
- Exactly one outstanding bus access at any time. reg_we and reg_re are never high together.

Decomposition:
- Package cfg_cmd_pkg holds:
  - Command code localparams (CMD_WR, CMD_RD, CMD_PING, CMD_BAD).
  - State encoding (IDLE, DECODE, BUS_WR, BUS_RD, RESP, CLR).
  - Response code defaults.
- No sub-module is needed. Timer and err_cnt are inline counters.

Test Plan:
- Write, zero-wait ack: frm_rdy with cfg_data=24'h05_1234, reg_ack tied high -> reg_we one cycle with addr 6'h05 and wdata 16'h1234; snd_rsp at cycle 3; rsp_data=16'hA5A5.
- Read, 3 wait cycles: cfg_data=24'h4A_0000, ack with reg_rdata=16'hBEEF on the 4th strobe cycle -> reg_re high for 4 cycles with addr 6'h0A; rsp_data=16'hBEEF; snd_rsp at cycle 6.
- Timeout: TIMEOUT=4, read with no ack -> reg_re high for exactly 4 cycles; rsp_data=16'hDEAD; err_cnt=1. Ack arriving on cycle 4 instead -> rsp_data=reg_rdata and err_cnt=0.
- PING and invalid: 24'h80_C0DE -> rsp_data=16'hC0DE at cycle 2. 24'hC0_0000 -> rsp_data=16'hEEEE and err_cnt increments. 256 invalid frames -> err_cnt=8'hFF.
- Handshake: frm_rdy held high for 3 cycles after the clr_frm_rdy rise -> clr_frm_rdy stays high until frm_rdy=0; no second dispatch of the same frame; snd_rsp pulses exactly once.
- Reset mid-BUS_RD: rst for 1 cycle -> reg_re=0 and busy=0 at the next edge; no snd_rsp; the next frame processes normally.
